// File: rtl/bobc_operativo.sv
// Operative block of the BOBC polynomial evaluator: X/H/S registers, operand muxes,
// adder and an iterative shift-add multiplier sequenced by an external control FSM.
module bobc_operativo #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] coef_a,
  input  logic [W-1:0] coef_b,
  input  logic [W-1:0] coef_c,
  input  logic         lx,
  input  logic [1:0]   m0,
  input  logic [1:0]   m1,
  input  logic [1:0]   m2,
  input  logic         h,
  input  logic         ls,
  input  logic         lh,
  input  logic         done,
  output logic         pronto,
  output logic [W-1:0] y,
  output logic         y_valid,
  output logic         err
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mul_state_t;

  mul_state_t    r_state, w_state_nxt;
  logic [W-1:0]  r_x, r_h, r_s;
  logic [W-1:0]  r_qc, r_mc, r_acc, r_product;
  logic [CW-1:0] r_count;
  logic          r_y_valid, r_err;

  logic [W-1:0]  w_p, w_m, w_q, w_r;
  logic          w_load_blocked;

  // Operand networks feeding the adder (P + Q) and the multiplier (Q * M).
  always_comb begin
    w_p = '0;
    w_m = r_x;
    w_q = '0;
    unique case (m0)
      2'b00:   w_p = '0;
      2'b01:   w_p = coef_a;
      2'b10:   w_p = coef_b;
      default: w_p = coef_c;
    endcase
    unique case (m1)
      2'b00:   w_m = r_x;
      2'b01:   w_m = r_h;
      2'b10:   w_m = coef_a;
      default: w_m = W'(1);
    endcase
    unique case (m2)
      2'b00:   w_q = '0;
      2'b01:   w_q = r_x;
      2'b10:   w_q = r_s;
      default: w_q = r_h;
    endcase
  end

  assign w_r            = h ? r_product : (w_p + w_q);
  assign pronto         = (r_state == S_DONE);
  // A product load requested before the multiplier finishes is refused and flagged.
  assign w_load_blocked = h && !pronto;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (h) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (!h)                 w_state_nxt = S_IDLE;
        else if (r_count == '0) w_state_nxt = S_DONE;
      end
      S_DONE:  if (!h) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is only ever written with non-blocking assignments so every register
  // sees the pre-edge values of the others (e.g. lx together with lh uses the old X).
  always_ff @(posedge ck) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Multiplier datapath: operands are captured at start so later mux changes are ignored.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_qc      <= '0;
      r_mc      <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (h) begin
            r_qc    <= w_q;
            r_mc    <= w_m;
            r_acc   <= '0;
            r_count <= CW'(W);
          end
        end
        S_BUSY: begin
          if (h && r_count != '0) begin
            if (r_mc[0]) r_acc <= r_acc + r_qc;
            r_qc    <= r_qc << 1;
            r_mc    <= r_mc >> 1;
            r_count <= r_count - CW'(1);
          end else if (h) begin
            r_product <= r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural registers, result-valid flag and sticky protocol error.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_x       <= '0;
      r_h       <= '0;
      r_s       <= '0;
      r_y_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (lx)                    r_x <= x_in;
      if (lh && !w_load_blocked) r_h <= w_r;
      if (ls && !w_load_blocked) r_s <= w_r;

      if (((lh || ls) && w_load_blocked) || (done && r_state == S_BUSY))
        r_err <= 1'b1;

      if (lx)        r_y_valid <= 1'b0;
      else if (done) r_y_valid <= 1'b1;
    end
  end

  assign y       = r_s;
  assign y_valid = r_y_valid;
  assign err     = r_err;

endmodule

// File: tb/tb_bobc_operativo.sv
// Directed bench for bobc_operativo: stimulus queues expected pronto-rise cycles and
// y values; a negedge monitor pops and compares them when the DUT presents them.
module tb_bobc_operativo;

  localparam int W = 8;

  logic         ck, rst;
  logic [W-1:0] x_in, coef_a, coef_b, coef_c;
  logic         lx, h, ls, lh, done;
  logic [1:0]   m0, m1, m2;
  logic         pronto, y_valid, err;
  logic [W-1:0] y;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int q_pronto[$];
  int q_y[$];

  bobc_operativo #(.W(W)) dut (
    .ck(ck), .rst(rst), .x_in(x_in),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .lx(lx), .m0(m0), .m1(m1), .m2(m2), .h(h), .ls(ls), .lh(lh), .done(done),
    .pronto(pronto), .y(y), .y_valid(y_valid), .err(err)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  always @(posedge ck) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event required none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pronto rising must match a queued cycle; y_valid rising must match a queued y.
  logic prev_pronto = 1'b0;
  logic prev_yv     = 1'b0;
  always @(negedge ck) begin
    if (!rst) begin
      if (pronto && !prev_pronto) begin
        if (q_pronto.size() == 0) unexpected("pronto_unexpected");
        else check("pronto_latency", cyc, q_pronto.pop_front());
      end
      if (y_valid && !prev_yv) begin
        if (q_y.size() == 0) unexpected("y_valid_unexpected");
        else check("y_on_valid", y, q_y.pop_front());
      end
    end
    prev_pronto = pronto;
    prev_yv     = y_valid;
  end

  task automatic tick();
    @(negedge ck);
  endtask

  // Raise h with the given operand selects; sampling edge is the next posedge,
  // so pronto should first be seen at the negedge 10 posedges from now.
  task automatic start_mult(input logic [1:0] sel_m, input logic [1:0] sel_q, input bit expect_rise);
    h  = 1'b1;
    m1 = sel_m;
    m2 = sel_q;
    if (expect_rise) q_pronto.push_back(cyc + 10);
  endtask

  task automatic wait_pronto(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pronto) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  initial begin
    rst = 1'b1; h = 1'b0; lx = 1'b0; ls = 1'b0; lh = 1'b0; done = 1'b0;
    m0 = 2'b00; m1 = 2'b00; m2 = 2'b00;
    x_in = '0; coef_a = 8'd2; coef_b = 8'd3; coef_c = 8'd5;
    repeat (2) tick();
    check("rst_pronto", pronto, 0);
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Horner flow: y = 2*16 + 3*4 + 5 = 49
    x_in = 8'd4; lx = 1'b1; tick(); lx = 1'b0;
    m0 = 2'b01; m2 = 2'b00; lh = 1'b1; tick(); lh = 1'b0;          // H = 2
    start_mult(2'b00, 2'b11, 1'b1); wait_pronto("t1_mul1_seen");
    lh = 1'b1; tick(); lh = 1'b0;                                   // H = 8
    h = 1'b0; m0 = 2'b10; m2 = 2'b11; lh = 1'b1; tick(); lh = 1'b0; // H = 11
    start_mult(2'b00, 2'b11, 1'b1); wait_pronto("t1_mul2_seen");
    lh = 1'b1; tick(); lh = 1'b0;                                   // H = 44
    h = 1'b0; m0 = 2'b11; m2 = 2'b11; ls = 1'b1; tick(); ls = 1'b0; // S = 49
    check("t1_y", y, 49);
    q_y.push_back(49);
    done = 1'b1; tick(); done = 1'b0;
    check("t1_y_valid", y_valid, 1);
    check("t1_err", err, 0);

    // Latency: 7 * 1 with h held high
    x_in = 8'd7; lx = 1'b1; tick(); lx = 1'b0;
    check("t2_y_valid_cleared", y_valid, 0);
    start_mult(2'b11, 2'b01, 1'b1); wait_pronto("t2_seen");
    ls = 1'b1; tick(); ls = 1'b0;
    check("t2_product", y, 7);
    check("t2_pronto_held", pronto, 1);
    h = 1'b0; tick();
    check("t2_pronto_drop", pronto, 0);

    // Wrap-around: X=200, H=3 loaded in the same cycle
    x_in = 8'd200; lx = 1'b1; coef_c = 8'd3; m0 = 2'b11; m2 = 2'b00; lh = 1'b1;
    tick(); lx = 1'b0; lh = 1'b0;
    start_mult(2'b01, 2'b01, 1'b1); wait_pronto("t3_seen");
    ls = 1'b1; tick(); ls = 1'b0;
    check("t3_product_wrap", y, 88);
    h = 1'b0; coef_c = 8'd255; m0 = 2'b11; m2 = 2'b01; ls = 1'b1; tick(); ls = 1'b0;
    check("t3_adder_wrap", y, 199);
    check("t3_err", err, 0);

    // Premature load while BUSY
    start_mult(2'b00, 2'b01, 1'b0); repeat (3) tick();
    lh = 1'b1; tick(); lh = 1'b0;
    check("t4_err_set", err, 1);
    h = 1'b0; m0 = 2'b00; m2 = 2'b11; ls = 1'b1; tick(); ls = 1'b0;
    check("t4_h_unchanged", y, 3);
    tick();
    check("t4_err_sticky", err, 1);

    // Reset in BUSY cycle 3
    start_mult(2'b00, 2'b01, 1'b0); repeat (3) tick();
    rst = 1'b1; h = 1'b0; tick(); rst = 1'b0;
    check("t5_pronto", pronto, 0);
    check("t5_y", y, 0);
    check("t5_y_valid", y_valid, 0);
    check("t5_err_cleared", err, 0);
    m0 = 2'b00; m2 = 2'b01; ls = 1'b1; tick(); ls = 1'b0;
    check("t5_x_zero", y, 0);
    m2 = 2'b10; m2 = 2'b11; ls = 1'b1; tick(); ls = 1'b0;
    check("t5_h_zero", y, 0);
    x_in = 8'd9; lx = 1'b1; tick(); lx = 1'b0;
    start_mult(2'b00, 2'b01, 1'b1); wait_pronto("t5_seen");
    ls = 1'b1; tick(); ls = 1'b0;
    check("t5_product", y, 81);

    // Abort then restart with X=5
    h = 1'b0; x_in = 8'd3; lx = 1'b1; tick(); lx = 1'b0;
    start_mult(2'b00, 2'b01, 1'b0); repeat (3) tick();
    h = 1'b0; x_in = 8'd5; lx = 1'b1; tick(); lx = 1'b0; tick();
    start_mult(2'b00, 2'b01, 1'b1); wait_pronto("t6_seen");
    ls = 1'b1; tick(); ls = 1'b0;
    check("t6_product", y, 25);
    check("t6_err", err, 0);

    // done while BUSY: flags error but still validates y
    h = 1'b0; tick();
    start_mult(2'b00, 2'b01, 1'b0); repeat (2) tick();
    q_y.push_back(25);
    done = 1'b1; tick(); done = 1'b0;
    check("t7_err", err, 1);
    check("t7_y_valid", y_valid, 1);
    h = 1'b0; tick();

    // done together with lx: lx wins
    x_in = 8'd1; lx = 1'b1; done = 1'b1; tick(); lx = 1'b0; done = 1'b0;
    check("t8_lx_wins", y_valid, 0);
    repeat (3) tick();

    check("pronto_queue_drained", q_pronto.size(), 0);
    check("y_queue_drained", q_y.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
